// File: rtl/delay_pkg.sv
// Shared types and constants for the modulated delay line.
package delay_pkg;

    localparam int FRAC_W    = 6;
    localparam int DELAY_MIN = 1 << FRAC_W;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_A,
        S_RD_B,
        S_INTERP,
        S_OUT
    } state_t;

    // Longest delay that still leaves room for the older interpolation tap.
    function automatic int delay_max(input int addr_w);
        return ((1 << addr_w) - 2) << FRAC_W;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Single-port sample buffer with registered read.
module delay_ram
    import delay_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  sample_t           wdata_i,
    output sample_t           rdata_o
);

    sample_t mem_q [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mod_delay_line.sv
// Chorus delay line: LFO-modulated fractional tap, linear interpolation,
// half dry plus half wet output.
module mod_delay_line
    import delay_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int BASE_DELAY = 661,
    parameter int MOD_SHIFT  = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic signed [15:0] sample_i,
    input  logic               sampleValid_i,
    input  logic signed [13:0] lfo_i,
    input  logic               lfoValid_i,
    output logic signed [15:0] sample_o,
    output logic               sampleValid_o,
    output logic               dropped_o
);

    localparam int DQ_W = ADDR_W + FRAC_W + 2;
    localparam int DL_W = ADDR_W + FRAC_W;

    localparam logic signed [DQ_W-1:0] DQ_BASE = DQ_W'(BASE_DELAY * (1 << FRAC_W));
    localparam logic signed [DQ_W-1:0] DQ_MIN  = DQ_W'(DELAY_MIN);
    localparam logic signed [DQ_W-1:0] DQ_MAX  = DQ_W'(delay_max(ADDR_W));
    localparam logic [DL_W-1:0]        DL_MIN  = DL_W'(DELAY_MIN);
    localparam logic [DL_W-1:0]        DL_MAX  = DL_W'(delay_max(ADDR_W));
    localparam logic [ADDR_W-1:0]      FILL_MAX = '1;

    state_t             state_q;
    logic [ADDR_W-1:0]  wrPtr_q;
    logic [ADDR_W-1:0]  fillCnt_q;
    logic signed [13:0] lfoReg_q;
    sample_t            dry_q;
    logic [DL_W-1:0]    delayQ_q;
    sample_t            a_q;
    sample_t            wet_q;

    logic signed [DQ_W-1:0] lfoExt;
    logic signed [DQ_W-1:0] delayRaw;
    logic [DL_W-1:0]        delayQ_d;
    logic [ADDR_W-1:0]      dInt;
    logic [FRAC_W-1:0]      frac;
    logic                   aValid;
    logic                   bValid;
    logic                   ramWe;
    logic [ADDR_W-1:0]      ramAddr;
    sample_t                ramRdata;
    sample_t                bSel;
    logic signed [16:0]     diff;
    logic signed [23:0]     prod;
    sample_t                wet_d;
    logic signed [16:0]     mixSum;

    assign lfoExt   = $signed({{(DQ_W-14){lfoReg_q[13]}}, lfoReg_q}) >>> MOD_SHIFT;
    assign delayRaw = DQ_BASE + lfoExt;

    always_comb begin
        delayQ_d = delayRaw[DL_W-1:0];
        if (delayRaw < DQ_MIN) begin
            delayQ_d = DL_MIN;
        end else if (delayRaw > DQ_MAX) begin
            delayQ_d = DL_MAX;
        end
    end

    assign dInt = delayQ_q[DL_W-1:FRAC_W];
    assign frac = delayQ_q[FRAC_W-1:0];

    // Taps older than what has been written since reset read as silence.
    assign aValid = dInt < fillCnt_q;
    assign bValid = ({1'b0, dInt} + (ADDR_W+1)'(1)) < {1'b0, fillCnt_q};

    // wrPtr has already advanced past the new sample during the read states.
    always_comb begin
        ramWe   = 1'b0;
        ramAddr = wrPtr_q;
        unique case (state_q)
            S_WRITE: ramWe   = 1'b1;
            S_RD_A:  ramAddr = wrPtr_q - dInt - ADDR_W'(1);
            S_RD_B:  ramAddr = wrPtr_q - dInt - ADDR_W'(2);
            default: ;
        endcase
    end

    delay_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ramWe),
        .addr_i  (ramAddr),
        .wdata_i (dry_q),
        .rdata_o (ramRdata)
    );

    assign bSel   = bValid ? ramRdata : '0;
    assign diff   = $signed({bSel[15], bSel}) - $signed({a_q[15], a_q});
    assign prod   = 24'(diff) * 24'($signed({1'b0, frac}));
    assign wet_d  = sample_t'(a_q + (prod >>> FRAC_W));
    assign mixSum = $signed({dry_q[15], dry_q}) + $signed({wet_q[15], wet_q});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            wrPtr_q       <= '0;
            fillCnt_q     <= '0;
            lfoReg_q      <= '0;
            dry_q         <= '0;
            delayQ_q      <= '0;
            a_q           <= '0;
            wet_q         <= '0;
            sample_o      <= '0;
            sampleValid_o <= 1'b0;
            dropped_o     <= 1'b0;
        end else begin
            sampleValid_o <= 1'b0;
            dropped_o     <= sampleValid_i && (state_q != S_IDLE);
            if (lfoValid_i) begin
                lfoReg_q <= lfo_i;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (sampleValid_i) begin
                        dry_q    <= sample_i;
                        delayQ_q <= delayQ_d;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wrPtr_q <= wrPtr_q + ADDR_W'(1);
                    if (fillCnt_q != FILL_MAX) begin
                        fillCnt_q <= fillCnt_q + ADDR_W'(1);
                    end
                    state_q <= S_RD_A;
                end
                S_RD_A: begin
                    state_q <= S_RD_B;
                end
                S_RD_B: begin
                    a_q     <= aValid ? ramRdata : '0;
                    state_q <= S_INTERP;
                end
                S_INTERP: begin
                    wet_q   <= wet_d;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    sample_o      <= sample_t'(mixSum >>> 1);
                    sampleValid_o <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_delay_line.sv
// Bench for mod_delay_line: two instances (centre delay 661 and 2) checked
// against a sample-history model of the chorus arithmetic.
module tb_mod_delay_line;

    localparam int ADDR_W    = 11;
    localparam int MOD_SHIFT = 0;
    localparam int FILL_MAX  = (1 << ADDR_W) - 1;
    localparam int DMAX      = ((1 << ADDR_W) - 2) * 64;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] sample_i;
    logic               sampleValid_i;
    logic signed [13:0] lfo_i;
    logic               lfoValid_i;
    logic signed [15:0] out1, out2;
    logic               vld1, vld2, drp1, drp2;

    int n_cmp = 0;
    int n_bad = 0;
    int hist[$];
    int lfo_m;

    always #5 clk = ~clk;

    mod_delay_line #(
        .ADDR_W(ADDR_W), .BASE_DELAY(661), .MOD_SHIFT(MOD_SHIFT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .sample_i(sample_i), .sampleValid_i(sampleValid_i),
        .lfo_i(lfo_i), .lfoValid_i(lfoValid_i),
        .sample_o(out1), .sampleValid_o(vld1), .dropped_o(drp1)
    );

    mod_delay_line #(
        .ADDR_W(ADDR_W), .BASE_DELAY(2), .MOD_SHIFT(MOD_SHIFT)
    ) dut_short (
        .clk_i(clk), .rst_i(rst),
        .sample_i(sample_i), .sampleValid_i(sampleValid_i),
        .lfo_i(lfo_i), .lfoValid_i(lfoValid_i),
        .sample_o(out2), .sampleValid_o(vld2), .dropped_o(drp2)
    );

    // Output for the newest sample in hist, for a given centre delay.
    function automatic int model(input int base);
        int n, fill, d, di, fr, a, b;
        n = hist.size();
        fill = (n > FILL_MAX) ? FILL_MAX : n;
        d = base * 64 + (lfo_m >>> MOD_SHIFT);
        if (d < 64) d = 64;
        if (d > DMAX) d = DMAX;
        di = d / 64;
        fr = d % 64;
        a = (di < fill) ? hist[n-1-di] : 0;
        b = (di + 1 < fill) ? hist[n-2-di] : 0;
        return (hist[n-1] + a + (((b - a) * fr) >>> 6)) >>> 1;
    endfunction

    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        sampleValid_i = 1'b0;
        lfoValid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        lfo_m = 0;
    endtask

    task automatic accept(input int s, input bit lv, input int l,
                          output int got1, output int got2,
                          output int exp1, output int exp2, output int lat);
        sample_i = 16'(s);
        lfo_i = 14'(l);
        lfoValid_i = lv;
        sampleValid_i = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            sampleValid_i = 1'b0;
            lfoValid_i = 1'b0;
        end while (!vld1 && lat < 20);
        got1 = int'(out1);
        got2 = int'(out2);
        hist.push_back(s);
        exp1 = model(661);
        exp2 = model(2);
        if (lv) lfo_m = l;
    endtask

    task automatic test_reset();
        sample_i = '0;
        lfo_i = '0;
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out1 !== 16'sd0) begin
            n_bad++; $display("FAIL reset_sample_o got %0d want 0", out1);
        end
        n_cmp++;
        if (vld1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got %b want 0", vld1);
        end
        n_cmp++;
        if (drp1 !== 1'b0) begin
            n_bad++; $display("FAIL reset_dropped got %b want 0", drp1);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_sample();
        int g1, g2, e1, e2, lat;
        do_reset();
        accept(1000, 1'b0, 0, g1, g2, e1, e2, lat);
        n_cmp++;
        if (lat !== 6) begin
            n_bad++; $display("FAIL first_latency got %0d want 6", lat);
        end
        n_cmp++;
        if (g1 !== 500) begin
            n_bad++; $display("FAIL first_value got %0d want 500", g1);
        end
        @(negedge clk);
        n_cmp++;
        if (vld1 !== 1'b0) begin
            n_bad++; $display("FAIL pulse_width got %b want 0", vld1);
        end
        n_cmp++;
        if (out1 !== 16'sd500) begin
            n_bad++; $display("FAIL hold_value got %0d want 500", out1);
        end
    endtask

    task automatic test_impulse_lfo0();
        int g1, g2, e1, e2, lat, want;
        do_reset();
        for (int i = 0; i <= 5 + 664; i++) begin
            accept((i == 5) ? 16000 : 0, 1'b0, 0, g1, g2, e1, e2, lat);
            want = (i == 5 || i == 5 + 661) ? 8000 : 0;
            n_cmp++;
            if (g1 !== want || lat !== 6) begin
                n_bad++;
                $display("FAIL impulse0 i=%0d got %0d lat %0d want %0d lat 6", i, g1, lat, want);
            end
        end
    endtask

    task automatic test_half_sample();
        int g1, g2, e1, e2, lat, want;
        do_reset();
        for (int i = 0; i <= 5 + 664; i++) begin
            accept((i == 5) ? 16000 : 0, i == 0, 32, g1, g2, e1, e2, lat);
            want = (i == 5) ? 8000 : (i == 5 + 661 || i == 5 + 662) ? 4000 : 0;
            n_cmp++;
            if (g1 !== want) begin
                n_bad++; $display("FAIL half_sample i=%0d got %0d want %0d", i, g1, want);
            end
        end
    endtask

    task automatic test_neg_lfo_clamp();
        int g1, g2, e1, e2, lat, want1, want2;
        do_reset();
        for (int i = 0; i <= 5 + 536; i++) begin
            accept((i == 5) ? 16000 : 0, i == 0, -8192, g1, g2, e1, e2, lat);
            want1 = (i == 5 || i == 5 + 533) ? 8000 : 0;
            want2 = (i == 5 || i == 5 + 1) ? 8000 : 0;
            n_cmp++;
            if (g1 !== want1) begin
                n_bad++; $display("FAIL neg_lfo i=%0d got %0d want %0d", i, g1, want1);
            end
            n_cmp++;
            if (g2 !== want2) begin
                n_bad++; $display("FAIL clamp_min i=%0d got %0d want %0d", i, g2, want2);
            end
        end
    endtask

    task automatic test_lfo_coincident();
        int g1, g2, e1, e2, lat, want;
        do_reset();
        for (int i = 0; i <= 5 + 663; i++) begin
            accept((i == 5) ? 16000 : 0, i == 5 + 661, 64, g1, g2, e1, e2, lat);
            want = (i == 5 || i == 5 + 661 || i == 5 + 662) ? 8000 : 0;
            n_cmp++;
            if (g1 !== want) begin
                n_bad++; $display("FAIL lfo_coincident i=%0d got %0d want %0d", i, g1, want);
            end
        end
    endtask

    task automatic test_dropped();
        int g1, g2, e1, e2, lat, s1, pulses;
        do_reset();
        for (int i = 0; i < 4; i++) accept(rnd16(), 1'b0, 0, g1, g2, e1, e2, lat);
        s1 = rnd16();
        sample_i = 16'(s1);
        sampleValid_i = 1'b1;
        @(negedge clk);
        sampleValid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sample_i = 16'(rnd16());
        sampleValid_i = 1'b1;
        @(negedge clk);
        sampleValid_i = 1'b0;
        n_cmp++;
        if (drp1 !== 1'b1 || drp2 !== 1'b1) begin
            n_bad++; $display("FAIL dropped_pulse got %b%b want 11", drp1, drp2);
        end
        @(negedge clk);
        n_cmp++;
        if (drp1 !== 1'b0 || vld1 !== 1'b0) begin
            n_bad++; $display("FAIL dropped_clear got drp %b vld %b want 0 0", drp1, vld1);
        end
        @(negedge clk);
        hist.push_back(s1);
        e1 = model(661);
        e2 = model(2);
        n_cmp++;
        if (vld1 !== 1'b1 || int'(out1) !== e1 || int'(out2) !== e2) begin
            n_bad++;
            $display("FAIL dropped_first vld %b got %0d/%0d want %0d/%0d", vld1, out1, out2, e1, e2);
        end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (vld1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL dropped_extra got %0d pulses want 0", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            accept(rnd16(), 1'b0, 0, g1, g2, e1, e2, lat);
            n_cmp++;
            if (g1 !== e1 || g2 !== e2) begin
                n_bad++; $display("FAIL dropped_after i=%0d got %0d/%0d want %0d/%0d", i, g1, g2, e1, e2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g1, g2, e1, e2, lat, pulses;
        do_reset();
        for (int i = 0; i < 6; i++) accept(rnd16(), 1'b0, 0, g1, g2, e1, e2, lat);
        sample_i = 16'(rnd16());
        sampleValid_i = 1'b1;
        @(negedge clk);
        sampleValid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        lfo_m = 0;
        pulses = 0;
        repeat (8) begin
            if (vld1 || vld2) pulses++;
            @(negedge clk);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++; $display("FAIL abort_valid got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (out1 !== 16'sd0 || out2 !== 16'sd0) begin
            n_bad++; $display("FAIL abort_out got %0d/%0d want 0/0", out1, out2);
        end
        for (int i = 0; i < 5; i++) begin
            accept(rnd16(), 1'b0, 0, g1, g2, e1, e2, lat);
            n_cmp++;
            if (g1 !== e1 || g2 !== e2 || lat !== 6) begin
                n_bad++; $display("FAIL abort_after i=%0d got %0d/%0d want %0d/%0d", i, g1, g2, e1, e2);
            end
        end
    endtask

    task automatic test_random();
        int g1, g2, e1, e2, lat;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            accept(rnd16(), $urandom_range(0, 7) == 0,
                   int'($signed(14'($urandom))), g1, g2, e1, e2, lat);
            n_cmp++;
            if (g1 !== e1 || g2 !== e2 || lat !== 6) begin
                n_bad++;
                $display("FAIL random i=%0d got %0d/%0d lat %0d want %0d/%0d lat 6", i, g1, g2, lat, e1, e2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_impulse_lfo0();
        test_half_sample();
        test_neg_lfo_clamp();
        test_lfo_coincident();
        test_dropped();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
